// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: rotates an active-low column strobe, debounces the
// row returns on scan ticks and presents one key code per physical press.
module keypad_scanner #(
   parameter int SCAN_DIV     = 1000,
   parameter int DEBOUNCE_CNT = 16
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [3:0] rows,
   output logic [3:0] cols,
   output logic [3:0] tecla,
   output logic       ready,
   input  logic       key
);

   localparam int DIV_W = $clog2(SCAN_DIV);
   localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CNT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);

   // Indexed by {row, col}; element 0 is the rightmost entry.
   localparam logic [15:0][3:0] KEY_MAP = {
      4'hD, 4'hE, 4'h0, 4'hF,
      4'hC, 4'h9, 4'h8, 4'h7,
      4'hB, 4'h6, 4'h5, 4'h4,
      4'hA, 4'h3, 4'h2, 4'h1
   };

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      PRESENT  = 2'd2,
      RELEASE  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [3:0]       rows_meta_q, rows_s_q;
   logic [DIV_W-1:0] div_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       col_q, col_d;
   logic [1:0]       row_q, row_d;
   logic [3:0]       cols_q;
   logic [3:0]       tecla_q, tecla_d;
   logic             ready_q, ready_d;
   logic             tick;
   logic             hit_valid;
   logic [1:0]       hit_row;

   assign tick  = (div_q == DIV_LAST);
   assign cols  = cols_q;
   assign tecla = tecla_q;
   assign ready = ready_q;

   // Lowest-index low row wins.
   always_comb begin
      hit_valid = 1'b0;
      hit_row   = 2'd0;
      for (int r = 3; r >= 0; r--) begin
         if (!rows_s_q[r]) begin
            hit_valid = 1'b1;
            hit_row   = 2'(r);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      col_d   = col_q;
      row_d   = row_q;
      tecla_d = tecla_q;
      ready_d = ready_q;
      case (state_q)
         SCAN: begin
            if (tick) begin
               if (hit_valid) begin
                  row_d   = hit_row;
                  cnt_d   = CNT_W'(1);
                  state_d = DEBOUNCE;
               end else begin
                  col_d = col_q + 2'd1;
               end
            end
         end
         DEBOUNCE: begin
            if (cnt_q == CNT_DONE) begin
               tecla_d = KEY_MAP[{row_q, col_q}];
               ready_d = 1'b1;
               cnt_d   = '0;
               state_d = PRESENT;
            end else if (tick) begin
               if (hit_valid && (hit_row == row_q)) begin
                  cnt_d = cnt_q + CNT_W'(1);
               end else begin
                  cnt_d   = '0;
                  col_d   = col_q + 2'd1;
                  state_d = SCAN;
               end
            end
         end
         PRESENT: begin
            if (key) begin
               ready_d = 1'b0;
               state_d = RELEASE;
            end
         end
         RELEASE: begin
            // Column stays frozen so a held key keeps us here without repeating.
            if (tick) begin
               if (rows_s_q == 4'b1111) begin
                  if (cnt_q == CNT_LAST) begin
                     cnt_d   = '0;
                     col_d   = 2'd0;
                     state_d = SCAN;
                  end else begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end else begin
                  cnt_d = '0;
               end
            end
         end
         default: state_d = SCAN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= SCAN;
         rows_meta_q <= 4'b1111;
         rows_s_q    <= 4'b1111;
         div_q       <= '0;
         cnt_q       <= '0;
         col_q       <= 2'd0;
         row_q       <= 2'd0;
         cols_q      <= 4'b1110;
         tecla_q     <= 4'b1111;
         ready_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         rows_meta_q <= rows;
         rows_s_q    <= rows_meta_q;
         div_q       <= tick ? '0 : div_q + DIV_W'(1);
         cnt_q       <= cnt_d;
         col_q       <= col_d;
         row_q       <= row_d;
         cols_q      <= ~(4'b0001 << col_d);
         tecla_q     <= tecla_d;
         ready_q     <= ready_d;
      end
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_CNT=3 and a
// combinational keypad model driven by a 16-bit pressed-key mask (bit = row*4+col).
module tb_keypad_scanner;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [3:0]  rows;
   logic [3:0]  cols;
   logic [3:0]  tecla;
   logic        ready;
   logic        key = 1'b0;
   logic [15:0] press_mask = 16'h0;
   logic        force_en = 1'b1;
   logic [3:0]  force_rows = 4'h0;
   int          checks_cnt = 0;
   int          errors_cnt = 0;

   always #5 clk = ~clk;

   always_comb begin
      rows = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (press_mask[r*4+c] && !cols[c]) rows[r] = 1'b0;
      if (force_en) rows = force_rows;
   end

   keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .rows    (rows),
      .cols    (cols),
      .tecla   (tecla),
      .ready   (ready),
      .key     (key)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks_cnt++;
      if (got !== exp) begin
         errors_cnt++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_ready(input int max, output int n);
      n = -1;
      for (int i = 1; i <= max; i++) begin
         @(negedge clk);
         if (ready) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic wait_cols(input logic [3:0] v, input int max, output int n);
      n = -1;
      for (int i = 1; i <= max; i++) begin
         @(negedge clk);
         if (cols == v) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic press_and_check(input logic [15:0] mask, input logic [3:0] code, input string tag);
      int n;
      press_mask = mask;
      wait_ready(300, n);
      check_eq({tag, " detect"}, n > 0, 1'b1);
      check_eq({tag, " code"}, tecla, code);
      $display("[tb] %s: ready after %0d cycles, tecla=%b", tag, n, tecla);
      key = 1'b1;
      @(negedge clk);
      key = 1'b0;
      check_eq({tag, " ready drop"}, ready, 1'b0);
      press_mask = 16'h0;
      repeat (24) @(negedge clk);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [3:0] rot_tab [5];
      int n;
      int bad;
      rot_tab = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};

      // 1. Reset and free-running column rotation
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_eq("reset cols", cols, 4'b1110);
      check_eq("reset tecla", tecla, 4'b1111);
      check_eq("reset ready", ready, 1'b0);
      reset_n  = 1'b1;
      force_en = 1'b0;
      bad = 0;
      for (int i = 1; i <= 16; i++) begin
         @(negedge clk);
         if (cols != rot_tab[i/4]) bad++;
      end
      check_eq("rotation", bad, 0);
      $display("[tb] reset and rotation done");

      // 2. Clean press of '6' (row 1, col 2)
      wait_cols(4'b1110, 20, n);
      press_mask = 16'h1 << 6;
      wait_cols(4'b1011, 20, n);
      check_eq("six col reached", n > 0, 1'b1);
      wait_ready(40, n);
      check_eq("six latency", n, 13);
      check_eq("six code", tecla, 4'b0110);
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (!ready || tecla != 4'b0110) bad++;
      end
      check_eq("six hold stable", bad, 0);
      key = 1'b1;
      @(negedge clk);
      key = 1'b0;
      check_eq("six ready drop", ready, 1'b0);
      check_eq("six tecla kept", tecla, 4'b0110);
      bad = 0;
      repeat (50) begin
         @(negedge clk);
         if (ready || cols != 4'b1011) bad++;
      end
      check_eq("six no repeat", bad, 0);
      press_mask = 16'h0;
      wait_cols(4'b1110, 40, n);
      check_eq("six rescan", n > 0, 1'b1);
      wait_cols(4'b1101, 8, n);
      check_eq("six resume rotate", n, 4);
      $display("[tb] press 6 done");

      // 3. Bounce on '8' (row 2, col 1): visible for two ticks only
      wait_cols(4'b1110, 20, n);
      press_mask = 16'h1 << 9;
      wait_cols(4'b1101, 8, n);
      check_eq("bounce col reached", n > 0, 1'b1);
      bad = 0;
      repeat (9) begin
         @(negedge clk);
         if (ready) bad++;
      end
      press_mask = 16'h0;
      wait_cols(4'b1011, 10, n);
      check_eq("bounce resume", n, 3);
      repeat (10) begin
         @(negedge clk);
         if (ready) bad++;
      end
      check_eq("bounce no ready", bad, 0);
      $display("[tb] bounce 8 done");

      // 4. Priority and assorted codes
      press_and_check(16'h0101, 4'b0001, "prio 1");
      press_and_check(16'h1 << 12, 4'b1111, "star");
      press_and_check(16'h1 << 14, 4'b1110, "hash");
      press_and_check(16'h1 << 15, 4'b1101, "D");
      press_and_check(16'h1 << 3, 4'b1010, "A");

      // 5. key held high across scan, debounce, present and release
      key = 1'b1;
      bad = 0;
      repeat (10) begin
         @(negedge clk);
         if (ready) bad++;
      end
      press_mask = 16'h1 << 5;
      wait_ready(300, n);
      check_eq("keyhold detect", n > 0, 1'b1);
      check_eq("keyhold code", tecla, 4'b0101);
      @(negedge clk);
      check_eq("keyhold pulse", ready, 1'b0);
      repeat (30) begin
         @(negedge clk);
         if (ready) bad++;
      end
      press_mask = 16'h0;
      repeat (40) begin
         @(negedge clk);
         if (ready) bad++;
      end
      check_eq("keyhold no extra", bad, 0);
      key = 1'b0;
      $display("[tb] key held handshake done");

      // 6. Reset during PRESENT with the key still held
      press_mask = 16'h1 << 10;
      wait_ready(300, n);
      check_eq("nine detect", n > 0, 1'b1);
      check_eq("nine code", tecla, 4'b1001);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      check_eq("midrst ready", ready, 1'b0);
      check_eq("midrst tecla", tecla, 4'b1111);
      check_eq("midrst cols", cols, 4'b1110);
      wait_ready(300, n);
      check_eq("nine redetect", n > 0, 1'b1);
      check_eq("nine recode", tecla, 4'b1001);
      key = 1'b1;
      @(negedge clk);
      key = 1'b0;
      check_eq("nine ready drop", ready, 1'b0);
      press_mask = 16'h0;
      repeat (24) @(negedge clk);
      $display("[tb] reset mid-operation done");

      $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
      $finish;
   end

endmodule
